// File: rtl/image_read_ctrl.sv
// image_read_ctrl: takes one layer-segment descriptor, writes the four image_read cfg words once, then
// launches image_read (cmd_repeat+1) times. Define IMAGE_READ_CTRL_TIMEOUT_EN to enable the BUSY watchdog.
module image_read_ctrl #(
    parameter int unsigned CFG_DWIDTH     = 32,
    parameter int unsigned CFG_AWIDTH     = 5,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter logic [CFG_AWIDTH-1:0] CFG_IR_IMG_W  = CFG_AWIDTH'(1),
    parameter logic [CFG_AWIDTH-1:0] CFG_IR_IMG_DH = CFG_AWIDTH'(2),
    parameter logic [CFG_AWIDTH-1:0] CFG_IR_PAD    = CFG_AWIDTH'(3),
    parameter logic [CFG_AWIDTH-1:0] CFG_IR_CONV   = CFG_AWIDTH'(4)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           cmd_img_w,
    input  logic [31:0]           cmd_img_dh,
    input  logic [31:0]           cmd_pad,
    input  logic [31:0]           cmd_conv,
    input  logic [15:0]           cmd_repeat,
    input  logic                  cmd_val,
    output logic                  cmd_rdy,
    output logic [CFG_DWIDTH-1:0] cfg_data,
    output logic [CFG_AWIDTH-1:0] cfg_addr,
    output logic                  cfg_valid,
    output logic                  next,
    input  logic                  image_last,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           run_cnt,
    output logic                  err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_KICK   = 3'd3;
    localparam logic [2:0] S_BUSY   = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    if (CFG_DWIDTH != 32) begin : g_bad_dwidth
        $error("image_read_ctrl: CFG_DWIDTH must be 32");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("image_read_ctrl: GAP_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("image_read_ctrl: TIMEOUT_CYCLES must be >= 1");
    end

    logic [2:0]            state_q, state_d;
    logic [31:0]           img_w_q, img_w_d;
    logic [31:0]           img_dh_q, img_dh_d;
    logic [31:0]           pad_q, pad_d;
    logic [31:0]           conv_q, conv_d;
    logic [15:0]           repeat_q, repeat_d;
    logic [1:0]            load_idx_q, load_idx_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic [16:0]           pass_cnt_q, pass_cnt_d;
    logic                  cmd_rdy_q, cmd_rdy_d;
    logic                  cfg_valid_q, cfg_valid_d;
    logic [CFG_AWIDTH-1:0] cfg_addr_q, cfg_addr_d;
    logic [CFG_DWIDTH-1:0] cfg_data_q, cfg_data_d;
    logic                  next_q, next_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
`ifdef IMAGE_READ_CTRL_TIMEOUT_EN
    logic [31:0]           to_cnt_q, to_cnt_d;
    logic                  err_q, err_d;
`endif

    // 17-bit pass count so cmd_repeat=0xFFFF (65536 passes) terminates even though run_cnt wraps.
    logic [16:0] pass_inc;
    logic        pass_last;
    assign pass_inc  = pass_cnt_q + 17'd1;
    assign pass_last = (pass_inc == ({1'b0, repeat_q} + 17'd1));

    always_comb begin
        state_d     = state_q;
        img_w_d     = img_w_q;
        img_dh_d    = img_dh_q;
        pad_d       = pad_q;
        conv_d      = conv_q;
        repeat_d    = repeat_q;
        load_idx_d  = load_idx_q;
        gap_cnt_d   = gap_cnt_q;
        pass_cnt_d  = pass_cnt_q;
        cmd_rdy_d   = 1'b0;
        cfg_valid_d = 1'b0;
        cfg_addr_d  = '0;
        cfg_data_d  = '0;
        next_d      = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef IMAGE_READ_CTRL_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                cmd_rdy_d = 1'b1;
                if (cmd_val && cmd_rdy_q) begin
                    img_w_d     = cmd_img_w;
                    img_dh_d    = cmd_img_dh;
                    pad_d       = cmd_pad;
                    conv_d      = cmd_conv;
                    repeat_d    = cmd_repeat;
                    pass_cnt_d  = '0;
                    load_idx_d  = '0;
                    busy_d      = 1'b1;
                    cmd_rdy_d   = 1'b0;
                    // First cfg word goes out straight from the command bus.
                    cfg_valid_d = 1'b1;
                    cfg_addr_d  = CFG_IR_IMG_W;
                    cfg_data_d  = CFG_DWIDTH'(cmd_img_w);
                    state_d     = S_LOAD;
`ifdef IMAGE_READ_CTRL_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                load_idx_d = load_idx_q + 2'd1;
                case (load_idx_q)
                    2'd0: begin
                        cfg_valid_d = 1'b1;
                        cfg_addr_d  = CFG_IR_IMG_DH;
                        cfg_data_d  = CFG_DWIDTH'(img_dh_q);
                    end
                    2'd1: begin
                        cfg_valid_d = 1'b1;
                        cfg_addr_d  = CFG_IR_PAD;
                        cfg_data_d  = CFG_DWIDTH'(pad_q);
                    end
                    2'd2: begin
                        cfg_valid_d = 1'b1;
                        cfg_addr_d  = CFG_IR_CONV;
                        cfg_data_d  = CFG_DWIDTH'(conv_q);
                    end
                    default: state_d = S_SETTLE;
                endcase
            end
            S_SETTLE: begin
                next_d  = 1'b1;
                state_d = S_KICK;
            end
            S_KICK: begin
                state_d = S_BUSY;
`ifdef IMAGE_READ_CTRL_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            S_BUSY: begin
                if (image_last) begin
                    pass_cnt_d = pass_inc;
                    if (pass_last) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end
                end
`ifdef IMAGE_READ_CTRL_TIMEOUT_EN
                else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                    if (to_cnt_d == 32'(TIMEOUT_CYCLES)) begin
                        err_d     = 1'b1;
                        busy_d    = 1'b0;
                        cmd_rdy_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
`endif
            end
            S_GAP: begin
                // Relaunch reuses the cfg already held by image_read.
                if (gap_cnt_q == GAP_LAST) begin
                    next_d  = 1'b1;
                    state_d = S_KICK;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            S_DONE: begin
                busy_d    = 1'b0;
                cmd_rdy_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            img_w_q     <= '0;
            img_dh_q    <= '0;
            pad_q       <= '0;
            conv_q      <= '0;
            repeat_q    <= '0;
            load_idx_q  <= '0;
            gap_cnt_q   <= '0;
            pass_cnt_q  <= '0;
            cmd_rdy_q   <= 1'b0;
            cfg_valid_q <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            next_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef IMAGE_READ_CTRL_TIMEOUT_EN
            to_cnt_q    <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            img_w_q     <= img_w_d;
            img_dh_q    <= img_dh_d;
            pad_q       <= pad_d;
            conv_q      <= conv_d;
            repeat_q    <= repeat_d;
            load_idx_q  <= load_idx_d;
            gap_cnt_q   <= gap_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            cmd_rdy_q   <= cmd_rdy_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_data_q  <= cfg_data_d;
            next_q      <= next_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef IMAGE_READ_CTRL_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign cmd_rdy   = cmd_rdy_q;
    assign cfg_valid = cfg_valid_q;
    assign cfg_addr  = cfg_addr_q;
    assign cfg_data  = cfg_data_q;
    assign next      = next_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign run_cnt   = pass_cnt_q[15:0];
`ifdef IMAGE_READ_CTRL_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_image_read_ctrl.sv
// Scoreboard bench for image_read_ctrl: stimulus predicts cfg/next/done events per cycle from the
// descriptor timing rules; a negedge monitor pops and compares them and checks busy/cmd_rdy/err levels.
`timescale 1ns/1ps
module tb_image_read_ctrl;
    localparam int GAP = 4;
    localparam int TO  = 64;
    localparam int BIG = 32'h7fff_ffff;
    localparam logic [4:0] AD_W    = 5'h01;
    localparam logic [4:0] AD_DH   = 5'h02;
    localparam logic [4:0] AD_PAD  = 5'h03;
    localparam logic [4:0] AD_CONV = 5'h04;

    typedef struct {
        int          kind;   // 0 cfg write, 1 next, 2 done
        int          stamp;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] r;
    } ev_t;

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] dh;
        logic [31:0] pad;
        logic [31:0] conv;
        logic [15:0] rep;
    } desc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cmd_img_w = '0, cmd_img_dh = '0, cmd_pad = '0, cmd_conv = '0;
    logic [15:0] cmd_repeat = '0;
    logic        cmd_val = 1'b0;
    logic        image_last = 1'b0;
    logic        cmd_rdy, cfg_valid, next, busy, done, err;
    logic [31:0] cfg_data;
    logic [4:0]  cfg_addr;
    logic [15:0] run_cnt;

    image_read_ctrl #(
        .CFG_DWIDTH(32), .CFG_AWIDTH(5), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO),
        .CFG_IR_IMG_W(AD_W), .CFG_IR_IMG_DH(AD_DH), .CFG_IR_PAD(AD_PAD), .CFG_IR_CONV(AD_CONV)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_img_w(cmd_img_w), .cmd_img_dh(cmd_img_dh), .cmd_pad(cmd_pad), .cmd_conv(cmd_conv),
        .cmd_repeat(cmd_repeat), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
        .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
        .next(next), .image_last(image_last), .busy(busy), .done(done),
        .run_cnt(run_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t exp_q[$];
    int  n_tests = 0, n_fail = 0;
    bit  mon_en = 1'b0;
    int  busy_lo = 1, busy_hi = 0, rdy_from = BIG, err_lo = 1, err_hi = 0;

    function automatic bit in_busy(int s);
        return (s >= busy_lo) && (s <= busy_hi);
    endfunction

    function automatic bit exp_rdy(int s);
        return (s >= rdy_from) && !in_busy(s);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic take(input int kind, input int s, input logic [31:0] a, input logic [31:0] b,
                        input logic [15:0] r);
        ev_t e;
        if (exp_q.size() == 0 || exp_q[0].stamp != s || exp_q[0].kind != kind) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event kind=%0d @cycle %0d: got addr 0x%0h data 0x%0h run_cnt %0d, expected none",
                     kind, s, a, b, r);
        end else begin
            e = exp_q.pop_front();
            if (kind == 0) begin
                chk("cfg_addr", a, e.a);
                chk("cfg_data", b, e.b);
            end
            chk("run_cnt_at_event", 32'(r), 32'(e.r));
        end
    endtask

    always @(negedge clk) begin
        int s;
        if (mon_en) begin
            s = cyc;
            while (exp_q.size() > 0 && exp_q[0].stamp < s) begin
                n_tests++;
                n_fail++;
                $display("FAIL missing_event kind=%0d: got nothing at cycle %0d, expected by %0d",
                         exp_q[0].kind, exp_q[0].stamp, s);
                void'(exp_q.pop_front());
            end
            if (cfg_valid) take(0, s, 32'(cfg_addr), cfg_data, run_cnt);
            if (next)      take(1, s, '0, '0, run_cnt);
            if (done)      take(2, s, '0, '0, run_cnt);
            chk("busy", 32'(busy), 32'(in_busy(s)));
            chk("cmd_rdy", 32'(cmd_rdy), 32'(exp_rdy(s)));
            chk("err", 32'(err), 32'((s >= err_lo) && (s <= err_hi)));
            if (!cfg_valid) begin
                chk("cfg_addr_idle", 32'(cfg_addr), 32'd0);
                chk("cfg_data_idle", cfg_data, 32'd0);
            end
            if (cfg_valid && next) chk("next_with_cfg", 32'(next), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int stamp, input logic [31:0] a, input logic [31:0] b,
                        input logic [15:0] r);
        ev_t e;
        e.kind = kind; e.stamp = stamp; e.a = a; e.b = b; e.r = r;
        exp_q.push_back(e);
    endtask

    function automatic desc_t rand_desc(int rep_max);
        desc_t d;
        d.w    = $urandom;
        d.dh   = $urandom;
        d.pad  = $urandom;
        d.conv = $urandom;
        d.rep  = 16'($urandom_range(0, rep_max));
        return d;
    endfunction

    // Reset raised at the current cycle c for n edges: all outputs clear from c+1.
    task automatic do_reset(input int n);
        int c;
        c = cyc;
        rst = 1'b1;
        cmd_val = 1'b0;
        image_last = 1'b0;
        while (exp_q.size() > 0 && exp_q[$].stamp > c) void'(exp_q.pop_back());
        if (busy_hi > c) busy_hi = c;
        if (err_hi > c) err_hi = c;
        rdy_from = c + n + 1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    // mode: 0 normal, 1 reset in LOAD, 2 reset in BUSY, 3 let watchdog expire
    task automatic run_desc(input desc_t d, input int wfix, input bit noise, input bit hold,
                            input desc_t nd, input int mode);
        int a_edge, b, e_edge, w;
        cmd_img_w = d.w; cmd_img_dh = d.dh; cmd_pad = d.pad; cmd_conv = d.conv; cmd_repeat = d.rep;
        cmd_val = 1'b1;
        while (!exp_rdy(cyc)) begin
            image_last = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end
        a_edge = cyc + 1;
        busy_lo = a_edge;
        busy_hi = BIG;
        if (err_hi >= a_edge) err_hi = a_edge - 1;
        push(0, a_edge,     32'(AD_W),    d.w,    16'd0);
        push(0, a_edge + 1, 32'(AD_DH),   d.dh,   16'd0);
        push(0, a_edge + 2, 32'(AD_PAD),  d.pad,  16'd0);
        push(0, a_edge + 3, 32'(AD_CONV), d.conv, 16'd0);
        push(1, a_edge + 5, '0, '0, 16'd0);
        image_last = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        cmd_val = 1'b0;
        cmd_img_w = $urandom; cmd_img_dh = $urandom; cmd_pad = $urandom; cmd_conv = $urandom;
        cmd_repeat = 16'($urandom);
        if (mode == 1) begin
            step();
            do_reset($urandom_range(1, 3));
            return;
        end
        b = a_edge + 6;
        for (int p = 0; p <= int'(d.rep); p++) begin
            while (cyc < b) begin
                image_last = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                step();
            end
            image_last = 1'b0;
            if (hold && p == int'(d.rep)) begin
                cmd_img_w = nd.w; cmd_img_dh = nd.dh; cmd_pad = nd.pad; cmd_conv = nd.conv;
                cmd_repeat = nd.rep;
                cmd_val = 1'b1;
            end
            if (mode == 3) begin
                err_lo = b + TO;
                err_hi = BIG;
                busy_hi = b + TO - 1;
                repeat (TO + 3) step();
                return;
            end
            w = (wfix >= 0) ? wfix : $urandom_range(0, 12);
            repeat (w) step();
            if (mode == 2) begin
                do_reset($urandom_range(1, 3));
                return;
            end
            image_last = 1'b1;
            e_edge = cyc + 1;
            if (p == int'(d.rep)) begin
                push(2, e_edge, '0, '0, 16'(p + 1));
                busy_hi = e_edge;
            end else begin
                push(1, e_edge + GAP, '0, '0, 16'(p + 1));
                b = e_edge + GAP + 1;
            end
            step();
        end
        image_last = 1'b0;
    endtask

    initial begin
        desc_t d, d2;
        repeat (3) step();
        rst = 1'b0;
        rdy_from = cyc + 1;
        mon_en = 1'b1;
        repeat (2) step();

        // single pass, image_last 33 cycles into BUSY
        d.w = 32'h7; d.dh = 32'h0003_0007; d.pad = 32'h0101_0101; d.conv = 32'h0002_0000; d.rep = 16'd0;
        run_desc(d, 33, 1'b0, 1'b0, d, 0);
        repeat (3) step();

        // three passes, no noise
        d = rand_desc(0);
        d.rep = 16'd2;
        run_desc(d, -1, 1'b0, 1'b0, d, 0);

        // stray image_last outside BUSY
        d = rand_desc(0);
        d.rep = 16'd3;
        run_desc(d, -1, 1'b1, 1'b0, d, 0);

        // cmd_val held through BUSY, back-to-back accept
        d = rand_desc(2);
        d2 = rand_desc(2);
        run_desc(d, -1, 1'b0, 1'b1, d2, 0);
        run_desc(d2, -1, 1'b1, 1'b0, d2, 0);

        // reset in LOAD and in BUSY, each followed by a clean run
        run_desc(rand_desc(2), -1, 1'b0, 1'b0, d, 1);
        run_desc(rand_desc(1), -1, 1'b0, 1'b0, d, 0);
        d = rand_desc(0);
        d.rep = 16'd2;
        run_desc(d, -1, 1'b0, 1'b0, d, 2);
        repeat (8) step();
        run_desc(rand_desc(1), -1, 1'b1, 1'b0, d, 0);

`ifdef IMAGE_READ_CTRL_TIMEOUT_EN
        run_desc(rand_desc(2), -1, 1'b0, 1'b0, d, 3);
        repeat (2) step();
        run_desc(rand_desc(1), -1, 1'b0, 1'b0, d, 0);
`endif

        for (int i = 0; i < 14; i++) begin
            d = rand_desc(4);
            d2 = rand_desc(4);
            run_desc(d, -1, 1'($urandom_range(0, 1)), 1'b0, d2, 0);
            repeat ($urandom_range(0, 3)) step();
        end

        repeat (GAP + 12) step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "tb_image_read_ctrl timed out");
    end

endmodule
